vga_line_fetcher: RTL and testbench
===================================

// Module: vga_line_fetcher
// PURPOSE
//  Memory-side counterpart of the VGA scan driver's line-read handshake. On each rising
//  edge of read_line_req it fetches one display line (line index read_line_addr) from frame
//  memory in fixed-length read bursts. It writes the line into ping-pong line buffer A or B,
//  selected by read_line_A_B. The driver reads that buffer on the next scanline.
// PARAMETERS
//  BURST_LEN   16    words per memory read burst; power of 2, 2..256
//  LINE_STRIDE 1024  words between line starts in memory; power of 2, fixed at 1024 (10 col bits)
//  MEM_AW      26    memory word-address width = 16 line bits + 10 column bits
// PORTS
//  vga_clk        in   1   pixel clock, all logic rising-edge
//  rst_n_w        in   1   async active-low reset
//  read_line_req  in   1   fetch request; rising edge starts a line fetch
//  read_line_A_B  in   1   target buffer, sampled at req rise: 0=A, 1=B
//  read_line_addr in   16  line index to fetch, sampled at req rise
//  line_words     in   11  words per line (640 or 1024); static while busy
//  mem_rd_req     out  1   burst read request, held until mem_rd_ack
//  mem_rd_addr    out  26  burst start word address {line[15:0], col[9:0]}
//  mem_rd_ack     in   1   1-cycle accept of current request
//  mem_rd_valid   in   1   read data word valid
//  mem_rd_data    in   16  read data word (RGB565)
//  buf_wr_addr    out  10  line-buffer write address (column)
//  buf_wr_data    out  16  line-buffer write data
//  buf_wrA_en     out  1   write strobe, buffer A
//  buf_wrB_en     out  1   write strobe, buffer B
//  busy           out  1   fetch in progress
//  line_done      out  1   1-cycle pulse after last word of a line is written
//  overrun        out  1   1-cycle pulse: new request arrived while busy
// BEHAVIOUR
//  Reset: FSM=IDLE, all outputs 0, col=0, req_d=0, pending=0; reset mid-burst drops the burst.
//  Edge detect: req_d <= read_line_req; rise = req & ~req_d. A falling edge has no effect.
//  States: IDLE -> REQ -> DATA -> (REQ | DONE) -> IDLE.
//  IDLE: on rise, latch line=read_line_addr, sel=read_line_A_B, col=0, busy<=1.
//    Next state is REQ. If line_words==0, go to DONE instead.
//  REQ: mem_rd_req=1, mem_rd_addr={line,col}. Both are stable until ack.
//    On ack: req<=0, beat=0, go to DATA.
//  DATA: count BURST_LEN valid beats. Each valid beat with col<line_words writes one word.
//    The write is registered, 1 cycle after valid: buf_wr_addr=col[9:0], buf_wr_data=mem_rd_data.
//    The strobe goes to A (sel=0) or B (sel=1); then col++.
//    Beats with col>=line_words are consumed without writing.
//    On the last beat: if col_next>=line_words or abort_pending, go to DONE; else go to REQ.
//  DONE: line_done=1 for one cycle, unless the fetch was aborted. busy<=0.
//    If pending, restart from the latched new request; else go to IDLE.
//  Rise while busy: overrun pulse; latch new line/sel into a pending slot (newest wins).
//    In REQ before ack: withdraw the request, restart immediately with the pending line.
//    In DATA: drain the accepted burst to completion (no writes), then restart.
//  Column arithmetic is 11-bit; col never exceeds 1024. mem_rd_addr column = col[9:0].
//  Per-line latency is BURST_LEN+ack wait per burst. The memory side must finish
//    line_words words within one line period; this block does not enforce it.
//  At most one outstanding burst. Valid beats seen outside DATA are ignored.
// TESTING
//  1 rise, line=5, A_B=0, line_words=640, ack after 2 cycles, 1 valid/cycle ->
//    40 bursts at addr 0x1400+16k; 640 buf_wrA_en writes, cols 0..639; line_done once; buf_wrB_en never.
//  2 line=0xFFFF, A_B=1, line_words=1024 -> last burst addr 0x3FFFFF0; writes on B only;
//    col 1023 is written; no address wrap into the next line.
//  3 line_words=600 (not a BURST_LEN multiple) -> 38 bursts; writes stop at col 599;
//    the final 8 beats are dropped; line_done fires.
//  4 rise mid-DATA (line 7, then line 8) -> overrun pulse; burst drains with no writes;
//    no line_done for line 7; line 8 fetched fully with line_done.
//  5 mem_rd_valid gaps (random stalls), then rst_n_w low mid-burst -> every output 0 at once;
//    after release, next rise fetches cleanly from col 0.

Source files
------------

// File: rtl/vga_line_fetcher.sv
// vga_line_fetcher: on each read_line_req rise, fetches one display line from
// frame memory in fixed-length bursts into ping-pong line buffer A or B.
module vga_line_fetcher #(
    parameter int BURST_LEN   = 16,
    parameter int LINE_STRIDE = 1024,
    parameter int MEM_AW      = 26
) (
    input  logic              vga_clk,
    input  logic              rst_n_w,
    input  logic              read_line_req,
    input  logic              read_line_A_B,
    input  logic [15:0]       read_line_addr,
    input  logic [10:0]       line_words,
    output logic              mem_rd_req,
    output logic [MEM_AW-1:0] mem_rd_addr,
    input  logic              mem_rd_ack,
    input  logic              mem_rd_valid,
    input  logic [15:0]       mem_rd_data,
    output logic [9:0]        buf_wr_addr,
    output logic [15:0]       buf_wr_data,
    output logic              buf_wrA_en,
    output logic              buf_wrB_en,
    output logic              busy,
    output logic              line_done,
    output logic              overrun
);
    localparam int CW = $clog2(LINE_STRIDE);
    localparam int BW = $clog2(BURST_LEN);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

    typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;

    state_t      state_q;
    state_t      state_d;
    logic        req_d;
    logic [15:0] line_q;
    logic        sel_q;
    logic [15:0] pend_line_q;
    logic        pend_sel_q;
    logic        pending_q;
    logic        abort_q;
    logic [10:0] col_q;
    logic [BW-1:0] beat_q;

    logic        rise;
    logic        in_fetch;
    logic        no_words;
    logic        abort_now;
    logic        wr_ok;
    logic        last_beat;
    logic        start;
    logic        restart;
    logic        launch;
    logic [10:0] col_next;
    logic [15:0] new_line;
    logic        new_sel;
    logic [MEM_AW-1:0] launch_addr;

    assign rise      = read_line_req & ~req_d;
    assign in_fetch  = (state_q != IDLE);
    assign no_words  = (line_words == 11'd0);
    assign abort_now = abort_q | rise;
    assign wr_ok     = (state_q == DATA) & mem_rd_valid & ~abort_now
                     & (col_q < line_words);
    assign col_next  = col_q + {10'd0, wr_ok};
    assign last_beat = mem_rd_valid & (beat_q == LAST_BEAT);
    assign start     = (state_q == IDLE) & rise;
    assign restart   = (state_q == DONE) & (rise | pending_q);

    // A rise in DONE is newer than anything parked in the pending slot
    assign new_line = (state_q == DONE && !rise) ? pend_line_q : read_line_addr;
    assign new_sel  = (state_q == DONE && !rise) ? pend_sel_q : read_line_A_B;

    assign launch      = (state_d == REQ) && (state_q != REQ);
    assign launch_addr = (state_q == DATA) ? {line_q, col_next[CW-1:0]}
                                           : {new_line, {CW{1'b0}}};

    always_ff @(posedge vga_clk or negedge rst_n_w) begin
        if (!rst_n_w) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (rise) state_d = no_words ? DONE : REQ;
            REQ: begin
                if (mem_rd_ack) state_d = DATA;
                else if (rise)  state_d = DONE;
            end
            DATA: begin
                if (last_beat)
                    state_d = (col_next >= line_words || abort_now) ? DONE : REQ;
            end
            DONE: begin
                if (restart) state_d = no_words ? DONE : REQ;
                else         state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge vga_clk or negedge rst_n_w) begin
        if (!rst_n_w) begin
            req_d       <= 1'b0;
            line_q      <= '0;
            sel_q       <= 1'b0;
            pend_line_q <= '0;
            pend_sel_q  <= 1'b0;
            pending_q   <= 1'b0;
            abort_q     <= 1'b0;
            col_q       <= '0;
            beat_q      <= '0;
            mem_rd_req  <= 1'b0;
            mem_rd_addr <= '0;
            buf_wr_addr <= '0;
            buf_wr_data <= '0;
            buf_wrA_en  <= 1'b0;
            buf_wrB_en  <= 1'b0;
            busy        <= 1'b0;
            line_done   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            req_d      <= read_line_req;
            buf_wrA_en <= 1'b0;
            buf_wrB_en <= 1'b0;
            line_done  <= 1'b0;
            overrun    <= rise & in_fetch;
            if (rise && in_fetch) begin
                pend_line_q <= read_line_addr;
                pend_sel_q  <= read_line_A_B;
                pending_q   <= 1'b1;
                abort_q     <= 1'b1;
            end
            if (state_q == REQ && (mem_rd_ack || rise)) begin
                mem_rd_req <= 1'b0;
                beat_q     <= '0;
            end
            if (state_q == DATA && mem_rd_valid) beat_q <= beat_q + 1'b1;
            if (wr_ok) begin
                buf_wr_addr <= col_q[CW-1:0];
                buf_wr_data <= mem_rd_data;
                buf_wrA_en  <= ~sel_q;
                buf_wrB_en  <= sel_q;
                col_q       <= col_next;
            end
            if (state_q == DONE) begin
                line_done <= ~abort_q;
                busy      <= 1'b0;
                abort_q   <= 1'b0;
            end
            if (start || restart) begin
                line_q    <= new_line;
                sel_q     <= new_sel;
                col_q     <= '0;
                busy      <= 1'b1;
                pending_q <= 1'b0;
                abort_q   <= 1'b0;
            end
            if (launch) begin
                mem_rd_req  <= 1'b1;
                mem_rd_addr <= launch_addr;
            end
        end
    end

endmodule

// File: tb/tb_vga_line_fetcher.sv
// tb_vga_line_fetcher: randomized line fetches against a burst memory model,
// checked against expected burst addresses and buffer writes per line.
module tb_vga_line_fetcher;
    localparam int BL = 16;

    logic        vga_clk = 1'b0;
    logic        rst_n_w = 1'b0;
    logic        read_line_req = 1'b0;
    logic        read_line_A_B = 1'b0;
    logic [15:0] read_line_addr = '0;
    logic [10:0] line_words = 11'd640;
    logic        mem_rd_req;
    logic [25:0] mem_rd_addr;
    logic        mem_rd_ack = 1'b0;
    logic        mem_rd_valid = 1'b0;
    logic [15:0] mem_rd_data = '0;
    logic [9:0]  buf_wr_addr;
    logic [15:0] buf_wr_data;
    logic        buf_wrA_en;
    logic        buf_wrB_en;
    logic        busy;
    logic        line_done;
    logic        overrun;

    int n_cmp = 0;
    int n_err = 0;

    logic [25:0] burst_q[$];
    logic [26:0] wr_q[$];
    int done_cnt = 0;
    int ovr_cnt = 0;
    int both_cnt = 0;
    int ack_delay = 2;
    bit stall = 1'b0;
    int mst = 0;

    vga_line_fetcher dut (
        .vga_clk(vga_clk), .rst_n_w(rst_n_w),
        .read_line_req(read_line_req), .read_line_A_B(read_line_A_B),
        .read_line_addr(read_line_addr), .line_words(line_words),
        .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
        .mem_rd_ack(mem_rd_ack), .mem_rd_valid(mem_rd_valid),
        .mem_rd_data(mem_rd_data), .buf_wr_addr(buf_wr_addr),
        .buf_wr_data(buf_wr_data), .buf_wrA_en(buf_wrA_en),
        .buf_wrB_en(buf_wrB_en), .busy(busy), .line_done(line_done),
        .overrun(overrun)
    );

    always #5 vga_clk = ~vga_clk;

    function automatic logic [15:0] mem_word(input logic [25:0] a);
        return a[15:0] ^ {a[25:16], a[5:0]} ^ 16'h5A3C;
    endfunction

    // Frame memory: acks after ack_delay, then streams BL beats
    initial begin : mem_model
        int wait_cnt;
        int left;
        logic [25:0] cur;
        wait_cnt = 0;
        left = 0;
        cur = '0;
        forever begin
            @(negedge vga_clk);
            mem_rd_ack = 1'b0;
            mem_rd_valid = 1'b0;
            if (!rst_n_w) mst = 0;
            else begin
                case (mst)
                    0: if (mem_rd_req) begin
                        wait_cnt = ack_delay;
                        mst = 1;
                    end
                    1: begin
                        if (!mem_rd_req) mst = 0;
                        else if (wait_cnt == 0) begin
                            mem_rd_ack = 1'b1;
                            cur = mem_rd_addr;
                            burst_q.push_back(cur);
                            left = BL;
                            mst = 2;
                        end else wait_cnt--;
                    end
                    default: begin
                        if (!(stall && $urandom_range(0, 3) == 0)) begin
                            mem_rd_valid = 1'b1;
                            mem_rd_data = mem_word(cur);
                            cur++;
                            left--;
                            if (left == 0) mst = 0;
                        end
                    end
                endcase
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge vga_clk);
            if (buf_wrA_en && buf_wrB_en) both_cnt++;
            if (buf_wrA_en || buf_wrB_en)
                wr_q.push_back({buf_wrB_en, buf_wr_addr, buf_wr_data});
            if (line_done) done_cnt++;
            if (overrun) ovr_cnt++;
        end
    end

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1, "watchdog expired");
    end

    task automatic clear_obs();
        burst_q.delete();
        wr_q.delete();
        done_cnt = 0;
        ovr_cnt = 0;
        both_cnt = 0;
    endtask

    task automatic pulse_req(input logic [15:0] line, input bit sel);
        @(negedge vga_clk);
        read_line_addr = line;
        read_line_A_B = sel;
        read_line_req = 1'b1;
        @(negedge vga_clk);
        read_line_req = 1'b0;
        read_line_addr = 16'($urandom);
        read_line_A_B = 1'($urandom);
    endtask

    task automatic wait_idle(input string nm);
        int cyc;
        cyc = 0;
        while (busy === 1'b1 && cyc < 20000) begin
            @(negedge vga_clk);
            cyc++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s timeout: busy=%b after %0d cycles, want 0", nm, busy, cyc);
        end
        repeat (3) @(negedge vga_clk);
    endtask

    task automatic check_fetch(input string nm, input logic [15:0] line,
                               input bit sel, input int lw,
                               input int b0, input int w0);
        int nb;
        logic [25:0] ea;
        logic [26:0] ew;
        logic [9:0] c10;
        nb = (lw + BL - 1) / BL;
        n_cmp++;
        if (burst_q.size() - b0 != nb) begin
            n_err++;
            $display("FAIL %s burst count: got %0d want %0d", nm, burst_q.size() - b0, nb);
        end
        for (int k = 0; k < nb && b0 + k < burst_q.size(); k++) begin
            c10 = 10'(k * BL);
            ea = {line, c10};
            n_cmp++;
            if (burst_q[b0 + k] !== ea) begin
                n_err++;
                $display("FAIL %s burst %0d addr: got %h want %h", nm, k, burst_q[b0 + k], ea);
            end
        end
        n_cmp++;
        if (wr_q.size() - w0 != lw) begin
            n_err++;
            $display("FAIL %s write count: got %0d want %0d", nm, wr_q.size() - w0, lw);
        end
        for (int c = 0; c < lw && w0 + c < wr_q.size(); c++) begin
            c10 = 10'(c);
            ew = {sel, c10, mem_word({line, c10})};
            n_cmp++;
            if (wr_q[w0 + c] !== ew) begin
                n_err++;
                $display("FAIL %s write %0d {B,addr,data}: got %h want %h", nm, c, wr_q[w0 + c], ew);
            end
        end
        n_cmp++;
        if (both_cnt != 0) begin
            n_err++;
            $display("FAIL %s both strobes: got %0d cycles want 0", nm, both_cnt);
        end
    endtask

    task automatic check_counts(input string nm, input int dn, input int ov);
        n_cmp++;
        if (done_cnt != dn) begin
            n_err++;
            $display("FAIL %s line_done pulses: got %0d want %0d", nm, done_cnt, dn);
        end
        n_cmp++;
        if (ovr_cnt != ov) begin
            n_err++;
            $display("FAIL %s overrun pulses: got %0d want %0d", nm, ovr_cnt, ov);
        end
    endtask

    task automatic test_reset();
        logic [63:0] outs;
        repeat (3) @(negedge vga_clk);
        outs = {mem_rd_req, mem_rd_addr, buf_wr_addr, buf_wr_data,
                buf_wrA_en, buf_wrB_en, busy, line_done, overrun};
        n_cmp++;
        if (outs !== '0) begin
            n_err++;
            $display("FAIL reset outputs: got %h want 0", outs);
        end
        rst_n_w = 1'b1;
        repeat (3) @(negedge vga_clk);
        outs = {mem_rd_req, mem_rd_addr, buf_wr_addr, buf_wr_data,
                buf_wrA_en, buf_wrB_en, busy, line_done, overrun};
        n_cmp++;
        if (outs !== '0) begin
            n_err++;
            $display("FAIL post-reset idle outputs: got %h want 0", outs);
        end
    endtask

    task automatic test_basic_line();
        clear_obs();
        ack_delay = 2;
        stall = 1'b0;
        line_words = 11'd640;
        pulse_req(16'd5, 1'b0);
        wait_idle("basic");
        check_fetch("basic", 16'd5, 1'b0, 640, 0, 0);
        check_counts("basic", 1, 0);
        n_cmp++;
        if (burst_q.size() == 0 || burst_q[0] !== 26'h0001400) begin
            n_err++;
            $display("FAIL basic first burst addr: got %h want 0001400",
                     burst_q.size() ? burst_q[0] : 26'h0);
        end
    endtask

    task automatic test_last_line();
        clear_obs();
        ack_delay = 1;
        line_words = 11'd1024;
        pulse_req(16'hFFFF, 1'b1);
        wait_idle("lastline");
        check_fetch("lastline", 16'hFFFF, 1'b1, 1024, 0, 0);
        check_counts("lastline", 1, 0);
        n_cmp++;
        if (burst_q.size() == 0 || burst_q[$] !== 26'h3FFFFF0) begin
            n_err++;
            $display("FAIL lastline final burst addr: got %h want 3fffff0",
                     burst_q.size() ? burst_q[$] : 26'h0);
        end
    endtask

    task automatic test_partial_line();
        clear_obs();
        ack_delay = 0;
        line_words = 11'd600;
        pulse_req(16'h0123, 1'b0);
        wait_idle("partial");
        check_fetch("partial", 16'h0123, 1'b0, 600, 0, 0);
        check_counts("partial", 1, 0);
    endtask

    task automatic test_abort_in_data();
        int cyc;
        int nb7;
        int n7;
        logic [26:0] ew;
        logic [9:0] c10;
        clear_obs();
        ack_delay = 1;
        stall = 1'b0;
        line_words = 11'd640;
        pulse_req(16'd7, 1'b0);
        cyc = 0;
        do begin
            @(negedge vga_clk);
            #1;
            cyc++;
        end while (!(burst_q.size() >= 3 && mst == 2) && cyc < 2000);
        nb7 = burst_q.size();
        pulse_req(16'd8, 1'b0);
        wait_idle("abort_data");
        check_counts("abort_data", 1, 1);
        n7 = wr_q.size() - 640;
        n_cmp++;
        if (n7 < 16 * (nb7 - 1) || n7 >= 16 * nb7) begin
            n_err++;
            $display("FAIL abort_data line7 writes: got %0d want %0d..%0d",
                     n7, 16 * (nb7 - 1), 16 * nb7 - 1);
        end
        for (int c = 0; c < n7 && c < wr_q.size(); c++) begin
            c10 = 10'(c);
            ew = {1'b0, c10, mem_word({16'd7, c10})};
            n_cmp++;
            if (wr_q[c] !== ew) begin
                n_err++;
                $display("FAIL abort_data line7 write %0d: got %h want %h", c, wr_q[c], ew);
            end
        end
        check_fetch("abort_data line8", 16'd8, 1'b0, 640, nb7, n7 < 0 ? 0 : n7);
    endtask

    task automatic test_abort_in_req();
        int cyc;
        clear_obs();
        ack_delay = 8;
        line_words = 11'd640;
        pulse_req(16'd7, 1'b1);
        cyc = 0;
        while (mem_rd_req !== 1'b1 && cyc < 100) begin
            @(negedge vga_clk);
            cyc++;
        end
        pulse_req(16'd9, 1'b1);
        wait_idle("abort_req");
        check_fetch("abort_req", 16'd9, 1'b1, 640, 0, 0);
        check_counts("abort_req", 1, 1);
    endtask

    task automatic test_random_lines();
        logic [15:0] line;
        bit sel;
        int lw;
        int pick;
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            clear_obs();
            line = 16'($urandom);
            sel = 1'($urandom);
            pick = $urandom_range(0, 3);
            lw = (pick == 0) ? 640 : (pick == 1) ? 1024 : $urandom_range(1, 1024);
            if (i == 4) lw = 0;
            ack_delay = $urandom_range(0, 3);
            line_words = 11'(lw);
            pulse_req(line, sel);
            wait_idle("random");
            check_fetch("random", line, sel, lw, 0, 0);
            check_counts("random", 1, 0);
        end
    endtask

    task automatic test_reset_mid_burst();
        int cyc;
        logic [63:0] outs;
        clear_obs();
        stall = 1'b1;
        ack_delay = 2;
        line_words = 11'd640;
        pulse_req(16'h0042, 1'b1);
        cyc = 0;
        do begin
            @(negedge vga_clk);
            #1;
            cyc++;
        end while (!(wr_q.size() >= 40 && mst == 2) && cyc < 3000);
        rst_n_w = 1'b0;
        #1;
        outs = {mem_rd_req, mem_rd_addr, buf_wr_addr, buf_wr_data,
                buf_wrA_en, buf_wrB_en, busy, line_done, overrun};
        n_cmp++;
        if (outs !== '0) begin
            n_err++;
            $display("FAIL midburst reset outputs: got %h want 0", outs);
        end
        repeat (3) @(negedge vga_clk);
        rst_n_w = 1'b1;
        repeat (2) @(negedge vga_clk);
        clear_obs();
        stall = 1'b0;
        pulse_req(16'h0321, 1'b0);
        wait_idle("after_reset");
        check_fetch("after_reset", 16'h0321, 1'b0, 640, 0, 0);
        check_counts("after_reset", 1, 0);
    endtask

    initial begin
        test_reset();
        test_basic_line();
        test_last_line();
        test_partial_line();
        test_abort_in_data();
        test_abort_in_req();
        test_random_lines();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
